// File: rtl/ahb3lite_sram_slave_if.sv
// AHB3-Lite bus bundle between the switch side (master) and an SRAM responder (slave).
interface ahb3lite_sram_slave_if #(
  parameter int unsigned HADDR_SIZE = 16,
  parameter int unsigned HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite SRAM responder: register-array memory with byte lanes, programmable
// wait states and a two-cycle ERROR response for illegal accesses.
module ahb3lite_sram_slave #(
  parameter int unsigned HADDR_SIZE  = 16,
  parameter int unsigned HDATA_SIZE  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic                  HCLK,
  input logic                  HRESET,
  ahb3lite_sram_slave_if.slave bus
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

  state_e                r_state, w_state_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic                  r_valid, w_valid_next;
  logic                  r_write;
  logic [IdxW-1:0]       r_idx;
  logic [3:0]            r_be;
  logic [HDATA_SIZE-1:0] r_mem [MEM_DEPTH];

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_oob;
  logic                  w_misalign;
  logic                  w_badsize;
  logic [3:0]            w_be;
  logic                  w_complete;
  logic                  w_commit;
  logic [HADDR_SIZE-3:0] w_word;
  logic                  w_unused;

  // Burst type, protection and lock carry no meaning for a plain memory.
  assign w_unused = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK};

  // Stalled only while counting down wait states or in the first error cycle.
  assign w_ready  = !((r_state == StWait && r_cnt != 4'd0) || r_state == StErr1);
  // Gating with w_ready keeps a stray HREADY from accepting mid-stall.
  assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & w_ready;

  assign w_word    = bus.HADDR[HADDR_SIZE-1:2];
  assign w_oob     = 32'(w_word) >= MEM_DEPTH;
  assign w_badsize = bus.HSIZE > 3'd2;
  assign w_illegal = w_oob | w_badsize | w_misalign;

  // Decode alignment and little-endian byte lanes from size and low address bits.
  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'b0000;
    case (bus.HSIZE)
      3'd0: w_be = 4'b0001 << bus.HADDR[1:0];
      3'd1: begin
        w_misalign = bus.HADDR[0];
        w_be       = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        w_misalign = |bus.HADDR[1:0];
        w_be       = 4'b1111;
      end
      default: ;
    endcase
  end

  // r_valid is only ever set for legal transfers, so ready marks the completing cycle.
  assign w_complete = r_valid & w_ready;
  // A pending write is dropped if reset lands on its completing cycle.
  assign w_commit   = w_complete & r_write & !HRESET;

  // Next-state: count down waits, walk the error pair, then idle or take a new accept.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_valid_next = r_valid;
    case (r_state)
      StWait: if (r_cnt != 4'd0) w_cnt_next = r_cnt - 4'd1;
      StErr1: w_state_next = StErr2;
      default: ;
    endcase
    if (w_ready) begin
      w_state_next = StIdle;
      w_valid_next = 1'b0;
      w_cnt_next   = 4'd0;
      if (w_accept) begin
        if (w_illegal) begin
          w_state_next = StErr1;
        end else begin
          w_valid_next = 1'b1;
          if (WAIT_STATES != 0) begin
            w_state_next = StWait;
            w_cnt_next   = 4'(WAIT_STATES);
          end
        end
      end
    end
  end

  // State register and address-phase capture for legal transfers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_be    <= 4'b0000;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_valid <= w_valid_next;
      if (w_accept && !w_illegal) begin
        r_write <= bus.HWRITE;
        r_idx   <= bus.HADDR[IdxW+1:2];
        r_be    <= w_be;
      end
    end
  end

  // Memory array: byte-masked write on the completing data cycle, never reset.
  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) r_mem[r_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  assign bus.HREADYOUT = w_ready;
  assign bus.HRESP     = (r_state == StErr1) || (r_state == StErr2);
  assign bus.HRDATA    = (r_valid && !r_write) ? r_mem[r_idx] : '0;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench for ahb3lite_sram_slave: three instances with 0, 3 and 5 wait states
// share one stimulus set; HSEL is steered to the instance under test.
module tb_ahb3lite_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel, hwrite;
  logic [15:0] haddr;
  logic [31:0] hwdata;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  int          tgt;
  int          checks   = 0;
  int          failures = 0;

  logic        o_rdy, o_resp;
  logic [31:0] o_rdata;

  always #5 clk = ~clk;

  ahb3lite_sram_slave_if bus0 ();
  ahb3lite_sram_slave_if bus1 ();
  ahb3lite_sram_slave_if bus2 ();

  assign bus0.HSEL = hsel && (tgt == 0);
  assign bus1.HSEL = hsel && (tgt == 1);
  assign bus2.HSEL = hsel && (tgt == 2);
  assign bus0.HADDR = haddr;  assign bus1.HADDR = haddr;  assign bus2.HADDR = haddr;
  assign bus0.HWDATA = hwdata; assign bus1.HWDATA = hwdata; assign bus2.HWDATA = hwdata;
  assign bus0.HWRITE = hwrite; assign bus1.HWRITE = hwrite; assign bus2.HWRITE = hwrite;
  assign bus0.HSIZE = hsize;  assign bus1.HSIZE = hsize;  assign bus2.HSIZE = hsize;
  assign bus0.HTRANS = htrans; assign bus1.HTRANS = htrans; assign bus2.HTRANS = htrans;
  assign bus0.HBURST = 3'd0;  assign bus1.HBURST = 3'd0;  assign bus2.HBURST = 3'd0;
  assign bus0.HPROT = 4'h3;   assign bus1.HPROT = 4'h3;   assign bus2.HPROT = 4'h3;
  assign bus0.HMASTLOCK = 1'b0; assign bus1.HMASTLOCK = 1'b0; assign bus2.HMASTLOCK = 1'b0;
  // Single responder per bus, so global ready is the responder's own ready.
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus1.HREADY = bus1.HREADYOUT;
  assign bus2.HREADY = bus2.HREADYOUT;

  ahb3lite_sram_slave #(.WAIT_STATES(0)) u_dut0 (.HCLK(clk), .HRESET(rst), .bus(bus0));
  ahb3lite_sram_slave #(.WAIT_STATES(3)) u_dut1 (.HCLK(clk), .HRESET(rst), .bus(bus1));
  ahb3lite_sram_slave #(.WAIT_STATES(5)) u_dut2 (.HCLK(clk), .HRESET(rst), .bus(bus2));

  always_comb begin
    o_rdy   = bus0.HREADYOUT;
    o_resp  = bus0.HRESP;
    o_rdata = bus0.HRDATA;
    if (tgt == 1) begin
      o_rdy = bus1.HREADYOUT; o_resp = bus1.HRESP; o_rdata = bus1.HRDATA;
    end else if (tgt == 2) begin
      o_rdy = bus2.HREADYOUT; o_resp = bus2.HRESP; o_rdata = bus2.HRDATA;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_rr(input string tag, input logic rdy, input logic resp);
    check({tag, "_rdy"}, 32'(o_rdy), 32'(rdy));
    check({tag, "_resp"}, 32'(o_resp), 32'(resp));
  endtask

  // Single non-pipelined transfer: address phase, data phase with expected waits or error.
  task automatic xfer(input logic wr, input logic [15:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [31:0] exp, input bit err,
                      input int waits, input string tag);
    hsel = 1'b1; htrans = 2'd2; haddr = addr; hwrite = wr; hsize = size;
    cyc();
    hsel = 1'b0; htrans = 2'd0; hwdata = wdata;
    if (err) begin
      check_rr({tag, "_err1"}, 1'b0, 1'b1);
      check({tag, "_err1_rdata"}, o_rdata, 32'h0);
      cyc();
      check_rr({tag, "_err2"}, 1'b1, 1'b1);
      cyc();
      check_rr({tag, "_okay"}, 1'b1, 1'b0);
    end else begin
      for (int i = 0; i < waits; i++) begin
        check_rr({tag, "_wait"}, 1'b0, 1'b0);
        cyc();
      end
      check_rr({tag, "_done"}, 1'b1, 1'b0);
      if (!wr) check({tag, "_rdata"}, o_rdata, exp);
      cyc();
    end
  endtask

  // Non-accepted address phase followed by a junk data cycle.
  task automatic noxfer(input logic sel, input logic [1:0] trans, input string tag);
    hsel = sel; htrans = trans; haddr = 16'h0010; hwrite = 1'b1; hsize = 3'd2;
    cyc();
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'h0BAD0BAD;
    check_rr({tag, "_d"}, 1'b1, 1'b0);
    cyc();
    check_rr({tag, "_i"}, 1'b1, 1'b0);
    check({tag, "_rdata"}, o_rdata, 32'h0);
  endtask

  initial begin
    tgt = 0; hsel = 1'b0; htrans = 2'd0; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
    hwdata = '0; rst = 1'b1;
    repeat (3) cyc();
    for (int t = 0; t < 3; t++) begin
      tgt = t;
      #1;
      check_rr("reset", 1'b1, 1'b0);
      check("reset_rdata", o_rdata, 32'h0);
    end
    rst = 1'b0;
    tgt = 0;
    cyc();

    // Zero-wait write then pipelined read of the same word.
    hsel = 1'b1; htrans = 2'd2; haddr = 16'h0010; hwrite = 1'b1; hsize = 3'd2;
    cyc();
    hwdata = 32'hDEADBEEF; hwrite = 1'b0;
    check_rr("wr10", 1'b1, 1'b0);
    cyc();
    hsel = 1'b0; htrans = 2'd0;
    check_rr("rd10", 1'b1, 1'b0);
    check("rd10_rdata", o_rdata, 32'hDEADBEEF);
    cyc();
    check_rr("idle10", 1'b1, 1'b0);
    check("idle10_rdata", o_rdata, 32'h0);

    // Byte and halfword lanes; off-lane data must be ignored.
    xfer(1'b1, 16'h0020, 3'd2, 32'h00000000, 32'h0, 1'b0, 0, "w20");
    xfer(1'b1, 16'h0021, 3'd0, 32'h1234AA78, 32'h0, 1'b0, 0, "b21");
    xfer(1'b1, 16'h0022, 3'd1, 32'h5566FFFF, 32'h0, 1'b0, 0, "h22");
    xfer(1'b0, 16'h0020, 3'd2, 32'h0, 32'h5566AA00, 1'b0, 0, "lanes");

    // Error responses and protection of memory from errored writes.
    xfer(1'b0, 16'h0400, 3'd2, 32'h0, 32'h0, 1'b1, 0, "err_oob");
    xfer(1'b0, 16'h0002, 3'd2, 32'h0, 32'h0, 1'b1, 0, "err_mis");
    xfer(1'b0, 16'h0010, 3'd3, 32'h0, 32'h0, 1'b1, 0, "err_size");
    xfer(1'b1, 16'h0000, 3'd2, 32'hCAFEF00D, 32'h0, 1'b0, 0, "w00");
    xfer(1'b1, 16'h0401, 3'd0, 32'hFFFFFFFF, 32'h0, 1'b1, 0, "err_wr_oob");
    xfer(1'b0, 16'h0000, 3'd2, 32'h0, 32'hCAFEF00D, 1'b0, 0, "mem00_kept");
    xfer(1'b1, 16'h0013, 3'd1, 32'hFFFFFFFF, 32'h0, 1'b1, 0, "err_wr_mis");
    xfer(1'b0, 16'h0010, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, 0, "mem10_kept");

    // IDLE/BUSY and deselected NONSEQ are ignored.
    noxfer(1'b1, 2'd0, "idle");
    noxfer(1'b1, 2'd1, "busy");
    noxfer(1'b0, 2'd2, "desel");
    xfer(1'b0, 16'h0010, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, 0, "mem10_nochg");

    // Three wait states, including back-to-back SEQ reads.
    tgt = 1;
    xfer(1'b1, 16'h0004, 3'd2, 32'hA5A50F0F, 32'h0, 1'b0, 3, "ws_w04");
    xfer(1'b1, 16'h0008, 3'd2, 32'h01020304, 32'h0, 1'b0, 3, "ws_w08");
    xfer(1'b0, 16'h0004, 3'd2, 32'h0, 32'hA5A50F0F, 1'b0, 3, "ws_r04");
    hsel = 1'b1; htrans = 2'd2; haddr = 16'h0004; hwrite = 1'b0; hsize = 3'd2;
    cyc();
    hsel = 1'b0; htrans = 2'd0;
    for (int i = 0; i < 3; i++) begin
      check_rr("seq_a_wait", 1'b0, 1'b0);
      cyc();
    end
    check_rr("seq_a_done", 1'b1, 1'b0);
    check("seq_a_rdata", o_rdata, 32'hA5A50F0F);
    hsel = 1'b1; htrans = 2'd3; haddr = 16'h0008;
    cyc();
    hsel = 1'b0; htrans = 2'd0;
    for (int i = 0; i < 3; i++) begin
      check_rr("seq_b_wait", 1'b0, 1'b0);
      cyc();
    end
    check_rr("seq_b_done", 1'b1, 1'b0);
    check("seq_b_rdata", o_rdata, 32'h01020304);
    cyc();
    check("seq_idle_rdata", o_rdata, 32'h0);
    xfer(1'b0, 16'h0400, 3'd2, 32'h0, 32'h0, 1'b1, 0, "ws_err");

    // Reset in the second wait cycle discards the pending write.
    tgt = 2;
    xfer(1'b1, 16'h0008, 3'd2, 32'h11112222, 32'h0, 1'b0, 5, "rs_w08");
    hsel = 1'b1; htrans = 2'd2; haddr = 16'h0008; hwrite = 1'b1; hsize = 3'd2;
    cyc();
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'h12345678;
    check_rr("rs_wait1", 1'b0, 1'b0);
    cyc();
    check_rr("rs_wait2", 1'b0, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_rr("rs_after", 1'b1, 1'b0);
    check("rs_after_rdata", o_rdata, 32'h0);
    xfer(1'b0, 16'h0008, 3'd2, 32'h0, 32'h11112222, 1'b0, 5, "rs_r08");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
